ecc_result_collector: RTL and testbench
=======================================

Name: ecc_result_collector

Overview:
- Downstream stage of the ECC encoder/decoder core.
- Captures each completed operation result (data_out, num_of_errors, operation type) when operation_done rises.
- Buffers results in a small FIFO and presents them to a consumer over a valid/ready handshake.
- Keeps saturating statistics counters (operations, corrected singles, detected doubles) and a sticky overflow flag.

Parameters:
DATA_WIDTH, 32, width of the core data_out word (8, 16 or 32)
DEPTH, 4, FIFO entries; power of two, at least 2
CNT_WIDTH, 16, width of each statistics counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
clr  input  1  synchronous clear of FIFO, counters and overflow
core_data  input  DATA_WIDTH  core data_out
core_nerr  input  2  core num_of_errors (00 none, 01 single corrected, 10 double detected)
core_done  input  1  core operation_done
core_op  input  2  core CTRL[1:0] (00 encode, 01 decode, 10 full channel)
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_data  output  DATA_WIDTH  head data
out_nerr  output  2  head error code
out_op  output  2  head operation code
fifo_count  output  $clog2(DEPTH)+1  occupancy
overflow  output  1  sticky: a capture was dropped
ops_cnt  output  CNT_WIDTH  capture events
single_cnt  output  CNT_WIDTH  captures with nerr=01
double_cnt  output  CNT_WIDTH  captures with nerr=10 or 11

Behaviour:
- Reset values: all outputs 0; done_q=0; FIFO empty; pointers 0.
- Capture event: core_done=1 while done_q=0, where done_q is core_done registered. A done held high for several cycles counts once.
- On a capture event in cycle N, entry {core_op, core_nerr, core_data} is sampled in cycle N.
  - The entry is visible at the head with out_valid=1 from cycle N+1 when the FIFO was empty.
  - FIFO is first-word-fall-through; out_* are driven combinationally from the head entry.
- While empty: out_valid=0, out_data/out_nerr/out_op=0.
- Pop: out_valid & out_ready at a clock edge removes the head. out_ready while empty is ignored.
- Push with FIFO not full: entry written, count+1.
- Push with FIFO full and no pop in the same cycle: entry dropped, overflow set to 1; count and contents unchanged.
- Push and pop in the same cycle:
  - Both take effect, count unchanged; this includes the full case, where the push is accepted.
  - If the FIFO was empty, the push is accepted and the pop is ignored (out_valid was 0).
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Statistics:
  - Every capture event increments ops_cnt, including dropped captures.
  - nerr=01 increments single_cnt.
  - nerr=10 or 11 increments double_cnt.
  - Counters saturate at all-ones and never wrap.
- overflow clears only on clr or reset.
- clr=1: next edge empties the FIFO and zeroes counters and overflow.
  - clr has priority over a push or pop in the same cycle; that capture is lost and not counted.
  - done_q still updates during clr.
- Asynchronous reset mid-operation returns everything to the reset values immediately. A core_done high at release does not capture until it falls and rises again.
- No internal FSM beyond FIFO control: state is {empty, partial, full}, derived from count.

Decomposition:
- Shared package ecc_pkg:
  - Op codes OP_ENC=2'b00, OP_DEC=2'b01, OP_FULL=2'b10.
  - Error codes NERR_NONE=2'b00, NERR_SINGLE=2'b01, NERR_DOUBLE=2'b10.
  - Entry width constant DATA_WIDTH+4.
- Sub-module ecc_sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Handles push, pop, clr, count, full and empty.
- Edge detection and statistics logic stay in the top block.

Test Plan:
- Single capture: core_done 0→1 for one cycle with data=0xA5, nerr=01, op=01, out_ready=0 → next cycle out_valid=1, out_data=0xA5, out_nerr=01, out_op=01, fifo_count=1, ops_cnt=1, single_cnt=1.
- Held done: core_done high for 3 cycles → exactly one entry, ops_cnt=1.
- Overflow: 5 captures (nerr=10) with out_ready=0 and DEPTH=4 → fifo_count=4, overflow=1, ops_cnt=5, double_cnt=5; drain with out_ready=1 returns the first four entries in order, then out_valid=0.
- Full plus simultaneous push/pop: FIFO full, capture with out_ready=1 → count stays 4, overflow stays 0, new entry lands at the tail.
- clr in the same cycle as a capture → fifo_count=0, all counters 0, overflow=0, no entry.
- Counter saturation with CNT_WIDTH=2: 5 captures with nerr=01 → single_cnt=3, ops_cnt=3. Async reset asserted mid-drain → all outputs 0 immediately.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared codes and sizing helpers for the ECC core and its downstream result path.
package ecc_pkg;

    localparam logic [1:0] OP_ENC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_FULL = 2'b10;

    localparam logic [1:0] NERR_NONE   = 2'b00;
    localparam logic [1:0] NERR_SINGLE = 2'b01;
    localparam logic [1:0] NERR_DOUBLE = 2'b10;

    // A result entry is {op[1:0], nerr[1:0], data}.
    localparam int ENTRY_EXTRA_W = 4;

    function automatic int entry_width(input int data_w);
        return data_w + ENTRY_EXTRA_W;
    endfunction

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'b00,
        FIFO_PARTIAL = 2'b01,
        FIFO_FULL    = 2'b10
    } fifo_state_e;

endpackage

// File: rtl/ecc_sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is taken only when a pop frees a slot in the same cycle.
module ecc_sync_fifo
    import ecc_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    fifo_state_e      w_state;
    logic             w_do_push;
    logic             w_do_pop;

    always_comb begin
        w_state = FIFO_PARTIAL;
        if (r_count == '0)
            w_state = FIFO_EMPTY;
        else if (r_count == CNT_W'(DEPTH))
            w_state = FIFO_FULL;
    end

    assign empty     = (w_state == FIFO_EMPTY);
    assign full      = (w_state == FIFO_FULL);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign rdata     = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_do_push && !w_do_pop)
                r_count <= r_count + CNT_W'(1);
            else if (w_do_pop && !w_do_push)
                r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage carries no reset: only slots behind a valid pointer are ever read out.
    always_ff @(posedge clk) begin
        if (w_do_push && !clr)
            r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ecc_result_collector.sv
// Captures ECC core results on the rising edge of operation_done, queues them for a
// valid/ready consumer and keeps saturating operation/error statistics.
module ecc_result_collector
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [DATA_WIDTH-1:0]    core_data,
    input  logic [1:0]               core_nerr,
    input  logic                     core_done,
    input  logic [1:0]               core_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [1:0]               out_nerr,
    output logic [1:0]               out_op,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [CNT_WIDTH-1:0]     ops_cnt,
    output logic [CNT_WIDTH-1:0]     single_cnt,
    output logic [CNT_WIDTH-1:0]     double_cnt
);
    localparam int ENTRY_W = entry_width(DATA_WIDTH);

    logic               r_done_q;
    logic               r_armed;
    logic               w_capture;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_head;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // r_armed blocks a capture for a done that was already high when reset released.
    assign w_capture = core_done & ~r_done_q & r_armed;
    assign w_drop    = w_capture & w_full & ~out_ready;

    ecc_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (w_capture),
        .pop   (out_ready),
        .wdata ({core_op, core_nerr, core_data}),
        .rdata (w_head),
        .count (fifo_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign out_valid = ~w_empty;
    assign out_data  = out_valid ? w_head[DATA_WIDTH-1:0]            : '0;
    assign out_nerr  = out_valid ? w_head[DATA_WIDTH+1:DATA_WIDTH]   : '0;
    assign out_op    = out_valid ? w_head[DATA_WIDTH+3:DATA_WIDTH+2] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_q <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_done_q <= core_done;
            if (!core_done)
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ops_cnt    <= '0;
            single_cnt <= '0;
            double_cnt <= '0;
            overflow   <= 1'b0;
        end else if (clr) begin
            ops_cnt    <= '0;
            single_cnt <= '0;
            double_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            if (w_capture) begin
                ops_cnt <= sat_inc(ops_cnt);
                if (core_nerr == NERR_SINGLE)
                    single_cnt <= sat_inc(single_cnt);
                if (core_nerr[1])
                    double_cnt <= sat_inc(double_cnt);
            end
            if (w_drop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ecc_result_collector.sv
// Randomized and directed bench for ecc_result_collector against a queue-based result model.
module tb_ecc_result_collector;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] core_data = '0;
    logic [1:0]    core_nerr = '0;
    logic          core_done = 1'b0;
    logic [1:0]    core_op   = '0;
    logic          out_ready = 1'b0;

    logic          a_valid, b_valid;
    logic [DW-1:0] a_data, b_data;
    logic [1:0]    a_nerr, b_nerr, a_op, b_op;
    logic [2:0]    a_count, b_count;
    logic          a_ovf, b_ovf;
    logic [15:0]   a_ops, a_single, a_double;
    logic [1:0]    b_ops, b_single, b_double;

    always #5 clk = ~clk;

    ecc_result_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .core_data(core_data), .core_nerr(core_nerr),
        .core_done(core_done), .core_op(core_op), .out_valid(a_valid), .out_ready(out_ready),
        .out_data(a_data), .out_nerr(a_nerr), .out_op(a_op), .fifo_count(a_count),
        .overflow(a_ovf), .ops_cnt(a_ops), .single_cnt(a_single), .double_cnt(a_double)
    );

    ecc_result_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(2)) u_dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .core_data(core_data), .core_nerr(core_nerr),
        .core_done(core_done), .core_op(core_op), .out_valid(b_valid), .out_ready(out_ready),
        .out_data(b_data), .out_nerr(b_nerr), .out_op(b_op), .fifo_count(b_count),
        .overflow(b_ovf), .ops_cnt(b_ops), .single_cnt(b_single), .double_cnt(b_double)
    );

    typedef struct packed {
        logic [1:0]    op;
        logic [1:0]    nerr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t        m_q[$];
    int unsigned m_ops, m_single, m_double;
    bit          m_ovf, m_prev_done, m_seen_low;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ops = 0; m_single = 0; m_double = 0;
        m_ovf = 0; m_prev_done = 0; m_seen_low = 0;
    endtask

    // One clock of the result path, evaluated from the inputs present this cycle.
    task automatic model_step();
        bit cap;
        cap = core_done && !m_prev_done && m_seen_low;
        if (clr) begin
            m_q.delete();
            m_ops = 0; m_single = 0; m_double = 0; m_ovf = 0;
        end else begin
            if (out_ready && m_q.size() > 0)
                void'(m_q.pop_front());
            if (cap) begin
                m_ops++;
                if (core_nerr == 2'b01) m_single++;
                if (core_nerr[1])       m_double++;
                if (m_q.size() < DEPTH) m_q.push_back({core_op, core_nerr, core_data});
                else                    m_ovf = 1;
            end
        end
        m_prev_done = core_done;
        if (!core_done) m_seen_low = 1;
    endtask

    task automatic check_all(input string ph);
        ent_t h;
        bit   v;
        v = (m_q.size() > 0);
        h = v ? m_q[0] : '0;
        chk({ph, ".valid"},   {63'd0, a_valid},  {63'd0, v});
        chk({ph, ".data"},    {32'd0, a_data},   {32'd0, h.data});
        chk({ph, ".nerr"},    {62'd0, a_nerr},   {62'd0, h.nerr});
        chk({ph, ".op"},      {62'd0, a_op},     {62'd0, h.op});
        chk({ph, ".count"},   {61'd0, a_count},  64'(m_q.size()));
        chk({ph, ".ovf"},     {63'd0, a_ovf},    {63'd0, m_ovf});
        chk({ph, ".ops"},     {48'd0, a_ops},    64'(sat(m_ops, 65535)));
        chk({ph, ".single"},  {48'd0, a_single}, 64'(sat(m_single, 65535)));
        chk({ph, ".double"},  {48'd0, a_double}, 64'(sat(m_double, 65535)));
        chk({ph, ".s.valid"}, {63'd0, b_valid},  {63'd0, v});
        chk({ph, ".s.data"},  {32'd0, b_data},   {32'd0, h.data});
        chk({ph, ".s.count"}, {61'd0, b_count},  64'(m_q.size()));
        chk({ph, ".s.ovf"},   {63'd0, b_ovf},    {63'd0, m_ovf});
        chk({ph, ".s.ops"},   {62'd0, b_ops},    64'(sat(m_ops, 3)));
        chk({ph, ".s.single"},{62'd0, b_single}, 64'(sat(m_single, 3)));
        chk({ph, ".s.double"},{62'd0, b_double}, 64'(sat(m_double, 3)));
    endtask

    task automatic cycle(input string ph);
        model_step();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic capture(input string ph, input logic [DW-1:0] d, input logic [1:0] n, input logic [1:0] o);
        core_data = d; core_nerr = n; core_op = o; core_done = 1'b1;
        cycle(ph);
        core_done = 1'b0;
        core_data = $urandom();
        cycle(ph);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        #11;
        rst = 1'b1;
        cycle("idle");

        capture("single", 32'hA5, 2'b01, 2'b01);
        chk("single.head", {32'd0, a_data}, 64'hA5);
        out_ready = 1'b1;
        cycle("pop1");
        out_ready = 1'b0;

        core_data = 32'h1234; core_nerr = 2'b00; core_op = 2'b10; core_done = 1'b1;
        repeat (3) cycle("held");
        core_done = 1'b0;
        cycle("held_fall");
        chk("held.count", {61'd0, a_count}, 64'd1);
        out_ready = 1'b1;
        cycle("held_pop");
        out_ready = 1'b0;

        for (int i = 0; i < 5; i++) capture("ovf_fill", 32'h100 + i, 2'b10, 2'(i % 3));
        chk("ovf.flag", {63'd0, a_ovf}, 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle("ovf_drain");
        out_ready = 1'b0;

        clr = 1'b1; cycle("clr0"); clr = 1'b0;
        for (int i = 0; i < 4; i++) capture("full_fill", $urandom(), 2'(i), 2'b00);
        out_ready = 1'b1;
        capture("full_pp", 32'hFEED_BEEF, 2'b01, 2'b10);
        out_ready = 1'b0;
        cycle("full_pp_hold");

        core_data = 32'hDEAD; core_nerr = 2'b01; core_done = 1'b1; clr = 1'b1;
        cycle("clr_cap");
        clr = 1'b0; core_done = 1'b0;
        cycle("clr_after");

        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) capture("sat", $urandom(), 2'b01, 2'b01);
        out_ready = 1'b0;

        for (int i = 0; i < 4; i++) capture("pre_rst", $urandom(), 2'(i), 2'b01);
        out_ready = 1'b1;
        cycle("drain_part");
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        out_ready = 1'b0;
        core_done = 1'b1;
        @(posedge clk);
        #1;
        check_all("in_rst");
        #2;
        rst = 1'b1;
        cycle("rel_done_hi");
        cycle("rel_done_hi2");
        core_done = 1'b0;
        cycle("rel_fall");
        capture("rel_rise", 32'h77, 2'b11, 2'b01);

        for (int i = 0; i < 400; i++) begin
            core_done = ($urandom_range(0, 2) != 0);
            core_data = $urandom();
            core_nerr = 2'($urandom());
            core_op   = 2'($urandom_range(0, 2));
            out_ready = ($urandom_range(0, 3) == 0);
            clr       = ($urandom_range(0, 59) == 0);
            cycle("rand");
        end
        clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
